// File: rtl/iter_alu.sv
// Execute-stage ALU for RV32I: single-cycle logic/arith/compare ops,
// iterative one-bit-per-cycle shifts, registered result with a valid pulse.
module iter_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            carry,
  output logic            overflow,
  output logic            sign,
  output logic            illegal,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b1000,
    OP_SLL   = 4'b1001,
    OP_SRL   = 4'b1010,
    OP_SRA   = 4'b1011,
    OP_SLT   = 4'b1100,
    OP_SLTU  = 4'b1101
  } op_t;

  state_t          state;
  logic [XLEN-1:0] work;
  logic [XLEN-1:0] work_nxt;
  logic [SHW-1:0]  cnt;
  logic            sh_left;
  logic            sh_arith;

  logic [SHW-1:0]  shamt;
  logic            is_sub;
  logic [XLEN:0]   sum;
  logic [XLEN-1:0] c_res;
  logic            c_carry;
  logic            c_ovf;
  logic            c_ill;
  logic            c_shift;
  logic            accept;

  assign in_ready = (state != SHIFT);
  assign busy     = ~in_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign shamt    = op_b[SHW-1:0];
  assign is_sub   = (alu_sel == OP_SUB);

  // SUB is a + ~b + 1, so the carry-out directly means "no borrow".
  assign sum = {1'b0, op_a} + {1'b0, (is_sub ? ~op_b : op_b)} + {{XLEN{1'b0}}, is_sub};

  always_comb begin
    c_res   = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_ill   = 1'b0;
    c_shift = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        c_res   = sum[XLEN-1:0];
        c_carry = sum[XLEN];
        c_ovf   = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      OP_SUB: begin
        c_res   = sum[XLEN-1:0];
        c_carry = sum[XLEN];
        c_ovf   = (op_a[XLEN-1] != op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
      end
      OP_AND:   c_res = op_a & op_b;
      OP_OR:    c_res = op_a | op_b;
      OP_XOR:   c_res = op_a ^ op_b;
      OP_PASSB: c_res = op_b;
      OP_SLT:   c_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  c_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      // A zero shift amount completes immediately with op_a unchanged.
      OP_SLL, OP_SRL, OP_SRA: begin
        c_res   = op_a;
        c_shift = (shamt != '0);
      end
      default:  c_ill = 1'b1;
    endcase
  end

  always_comb begin
    work_nxt = '0;
    if (sh_left) work_nxt = {work[XLEN-2:0], 1'b0};
    else         work_nxt = {(sh_arith & work[XLEN-1]), work[XLEN-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      sign      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (c_shift) begin
              work     <= op_a;
              cnt      <= shamt;
              sh_left  <= (alu_sel == OP_SLL);
              sh_arith <= (alu_sel == OP_SRA);
              state    <= SHIFT;
            end else begin
              result    <= c_res;
              zero      <= (c_res == '0);
              carry     <= c_carry;
              overflow  <= c_ovf;
              sign      <= c_res[XLEN-1];
              illegal   <= c_ill;
              out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            work <= work_nxt;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
              result    <= work_nxt;
              zero      <= (work_nxt == '0);
              carry     <= 1'b0;
              overflow  <= 1'b0;
              sign      <= work_nxt[XLEN-1];
              illegal   <= 1'b0;
              out_valid <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu; expected values are hand-computed.
module tb_iter_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        sign;
  logic        illegal;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  iter_alu #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_sel  (alu_sel),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .out_valid(out_valid),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .sign     (sign),
    .illegal  (illegal),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    alu_sel  = s;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
  endtask

  initial begin
    int lat;
    int seen;

    rst_n = 1'b1; in_valid = 1'b0; alu_sel = '0; op_a = '0; op_b = '0; flush = 1'b0;
    #3 rst_n = 1'b0;
    step(); step();
    chk("rst_result",   result,    32'h0);
    chk("rst_outvalid", {31'b0, out_valid}, 32'h0);
    chk("rst_inready",  {31'b0, in_ready},  32'h1);
    chk("rst_zero",     {31'b0, zero},      32'h0);
    chk("rst_illegal",  {31'b0, illegal},   32'h0);
    rst_n = 1'b1;
    step();

    // back-to-back single-cycle ops
    drive(4'b0010, 32'h7FFF_FFFF, 32'h1);
    step();
    chk("add_valid", {31'b0, out_valid}, 32'h1);
    chk("add_res",   result,             32'h8000_0000);
    chk("add_ovf",   {31'b0, overflow},  32'h1);
    chk("add_carry", {31'b0, carry},     32'h0);
    chk("add_sign",  {31'b0, sign},      32'h1);
    drive(4'b0110, 32'd5, 32'd5);
    step();
    chk("sub_valid", {31'b0, out_valid}, 32'h1);
    chk("sub_res",   result,             32'h0);
    chk("sub_zero",  {31'b0, zero},      32'h1);
    chk("sub_carry", {31'b0, carry},     32'h1);
    chk("sub_ovf",   {31'b0, overflow},  32'h0);
    drive(4'b1101, 32'h1, 32'hFFFF_FFFF);
    step();
    chk("sltu_valid", {31'b0, out_valid}, 32'h1);
    chk("sltu_res",   result,             32'h1);
    drive(4'b0110, 32'd3, 32'd5);
    step();
    chk("sub_neg_res",   result,            32'hFFFF_FFFE);
    chk("sub_neg_carry", {31'b0, carry},    32'h0);
    drive(4'b1100, 32'hFFFF_FFFF, 32'h1);
    step();
    chk("slt_res", result, 32'h1);
    drive(4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF);
    step();
    chk("xor_res", result, 32'hFF00_EDCB);
    in_valid = 1'b0;
    step();
    chk("pulse_low", {31'b0, out_valid}, 32'h0);

    // SRA by 4
    drive(4'b1011, 32'h8000_0000, 32'd4);
    step();
    in_valid = 1'b0;
    chk("sra_acc_valid", {31'b0, out_valid}, 32'h0);
    chk("sra_acc_ready", {31'b0, in_ready},  32'h0);
    chk("sra_busy",      {31'b0, busy},      32'h1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("sra_mid_ready", {31'b0, in_ready},  32'h0);
      chk("sra_mid_valid", {31'b0, out_valid}, 32'h0);
    end
    step();
    chk("sra_valid", {31'b0, out_valid}, 32'h1);
    chk("sra_res",   result,             32'hF800_0000);
    chk("sra_ready", {31'b0, in_ready},  32'h1);

    // SLL 1 by 31: bounded wait for completion
    drive(4'b1001, 32'h1, 32'd31);
    step();
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (out_valid && lat < 0) lat = i;
    end
    chk("sll31_lat", lat, 32'd31);
    chk("sll31_res", result, 32'h8000_0000);

    // SRL by 0 (op_b=32 -> shamt bits are zero)
    drive(4'b1010, 32'hA5A5_0000, 32'd32);
    step();
    in_valid = 1'b0;
    chk("srl0_valid", {31'b0, out_valid}, 32'h1);
    chk("srl0_res",   result,             32'hA5A5_0000);
    chk("srl0_ready", {31'b0, in_ready},  32'h1);

    // flush mid-shift
    drive(4'b1001, 32'h3, 32'd10);
    step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_ready", {31'b0, in_ready},  32'h1);
    chk("flush_res",   result,             32'hA5A5_0000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("flush_quiet", seen, 32'd0);

    // flush beats in_valid in IDLE
    drive(4'b0010, 32'd1, 32'd2);
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flushacc_valid", {31'b0, out_valid}, 32'h0);
    chk("flushacc_res",   result,             32'hA5A5_0000);
    step();
    chk("flushacc_late",  {31'b0, out_valid}, 32'h0);

    // illegal and PASSB
    drive(4'b1111, 32'd5, 32'd6);
    step();
    chk("ill_valid", {31'b0, out_valid}, 32'h1);
    chk("ill_res",   result,             32'h0);
    chk("ill_zero",  {31'b0, zero},      32'h1);
    chk("ill_flag",  {31'b0, illegal},   32'h1);
    drive(4'b1000, 32'hDEAD_BEEF, 32'h1234_5000);
    step();
    in_valid = 1'b0;
    chk("passb_res",  result,           32'h1234_5000);
    chk("passb_ill",  {31'b0, illegal}, 32'h0);
    chk("passb_zero", {31'b0, zero},    32'h0);

    // stall hold: ADD presented during SHIFT waits for in_ready
    drive(4'b1010, 32'h0000_00F0, 32'd3);
    step();
    drive(4'b0010, 32'd100, 32'd23);
    step();
    chk("stall_v1", {31'b0, out_valid}, 32'h0);
    step();
    chk("stall_v2", {31'b0, out_valid}, 32'h0);
    step();
    chk("stall_srl_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_srl_res",   result,             32'h0000_001E);
    step();
    in_valid = 1'b0;
    chk("stall_add_valid", {31'b0, out_valid}, 32'h1);
    chk("stall_add_res",   result,             32'd123);
    step();
    chk("stall_once", {31'b0, out_valid}, 32'h0);

    // asynchronous reset mid-shift
    drive(4'b1001, 32'h1, 32'd20);
    step();
    in_valid = 1'b0;
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",  {31'b0, in_ready},  32'h1);
    chk("arst_res",    result,             32'h0);
    chk("arst_valid",  {31'b0, out_valid}, 32'h0);
    chk("arst_sign",   {31'b0, sign},      32'h0);
    chk("arst_carry",  {31'b0, carry},     32'h0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("arst_quiet", seen, 32'd0);
    drive(4'b0010, 32'd2, 32'd3);
    step();
    in_valid = 1'b0;
    chk("post_rst_valid", {31'b0, out_valid}, 32'h1);
    chk("post_rst_res",   result,             32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/iter_alu.md
Name: iter_alu

Overview:
- Execute-stage ALU that consumes the 4-bit ALU selection code produced by the ALU control unit.
- Computes the result and branch flags for the RV32I integer operations.
- Logical, arithmetic and compare ops complete in one cycle.
- Shifts (SLL/SRL/SRA) run iteratively, one bit per cycle, to save area. The pipeline stalls on busy.
- Output is registered with a valid pulse. A flush input aborts in-flight work on pipeline redirect.

Parameters:
- XLEN, 32, operand/result width; power of two ≥8. Local SHW = log2(XLEN), the shift-amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; = (state != SHIFT)
- alu_sel  in  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0011 XOR, 1001 SLL, 1010 SRL, 1011 SRA, 1100 SLT, 1101 SLTU, 1000 PASSB (LUI); all others illegal
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B; shift amount = op_b[SHW-1:0]
- flush  in  1  abort current op and discard the pending result
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  XLEN  registered result
- zero  out  1  result == 0
- carry  out  1  ADD: carry-out. SUB: 1 if op_a ≥ op_b unsigned (no borrow). Else 0.
- overflow  out  1  signed overflow for ADD/SUB. Else 0.
- sign  out  1  result[XLEN-1]
- illegal  out  1  sampled with out_valid: alu_sel was not a legal code
- busy  out  1  = !in_ready

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - result=0, zero=0, carry=0, overflow=0, sign=0.
  - out_valid=0, illegal=0, shift counter=0.
  - Reset mid-shift abandons the op with no out_valid.
- States: IDLE, SHIFT.
- Accept: on a rising edge with in_valid && in_ready && !flush. Operands and alu_sel are captured at accept.
- Single-cycle ops (all non-shift codes, plus shifts with shamt=0):
  - Result, flags and out_valid=1 are registered on the accepting edge. Latency 1.
  - State stays IDLE, so a new op may be accepted every cycle and out_valid may be high on consecutive cycles.
- Shift with shamt≥1:
  - On the accepting edge: load working reg = op_a, count = shamt, state → SHIFT. out_valid=0 that cycle.
  - Each SHIFT edge shifts the working reg by one bit and decrements count.
    - SLL: zero-fill on the right.
    - SRL: zero-fill on the left.
    - SRA: replicate the MSB.
  - On the edge where count goes 1→0: result = working reg, out_valid=1, state → IDLE.
  - Total latency = shamt cycles from accept. Maximum XLEN-1.
- Arithmetic:
  - ADD/SUB are modulo 2^XLEN. SUB = op_a + ~op_b + 1; carry is the carry-out of that sum.
  - overflow = operands' signs agree (ADD) or differ (SUB) and the result sign differs from op_a.
  - SLT/SLTU: result = {XLEN-1 zeros, lt} with signed/unsigned compare.
  - PASSB: result = op_b.
  - zero and sign always reflect the registered result.
  - For non-ADD/SUB ops, carry=0 and overflow=0.
- Illegal alu_sel (e.g. 1111): single-cycle completion with result=0, zero=1, illegal=1, other flags 0.
- out_valid is a pulse. result and flags hold their last values until the next completion.
- flush:
  - In IDLE: suppresses any accept that cycle. flush beats in_valid.
  - In SHIFT: returns to IDLE at the next edge, with no out_valid and result unchanged.
  - If flush coincides with the completing edge, the completion is suppressed.
- in_valid while busy: ignored. The upstream holds the op via the stall.

Test Plan:
- Reset: hold rst_n=0 mid-SHIFT → all outputs 0 and in_ready=1 immediately (asynchronous); after release the next op is accepted normally.
- Back-to-back single-cycle ops:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, carry=0.
  - Next cycle: SUB 5-5 → result 0, zero=1, carry=1.
  - Next cycle: SLTU 1<0xFFFFFFFF → result 1.
  - out_valid high on three consecutive cycles.
- Iterative shifts:
  - SRA 0x80000000 by 4 → result 0xF8000000, out_valid exactly 4 cycles after accept, in_ready low for cycles 1–3 after accept.
  - SLL by 31 of 1 → 0x80000000 after 31 cycles.
  - SRL by 0 → latency 1, result = op_a.
- Flush:
  - Start SLL by 10 and assert flush on cycle 5 → no out_valid, result keeps its prior value, in_ready=1 next cycle.
  - flush together with in_valid in IDLE → no accept.
- Illegal/pass codes:
  - alu_sel=1111 → result 0, zero=1, illegal=1.
  - alu_sel=1000, op_b=0x12345000 → result 0x12345000, illegal=0.
- Stall hold: in_valid asserted with a new ADD during SHIFT → ignored until in_ready=1, then accepted and completes 1 cycle later with the correct sum.
